approx_mul_pipe: RTL and testbench

APPROX_MUL_PIPE -- requirements
Module: approx_mul_pipe

---
 rtl/approx_mul_pkg.sv | 17 +
 rtl/approx_pp_compress.sv | 45 ++++
 rtl/approx_mul_pipe.sv | 124 ++++++++++++
 tb/tb_approx_mul_pipe.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/approx_mul_pkg.sv
// Shared constants and helpers for the approximate multiplier pipeline.
// Holds the legal parameter ranges and the truncation compensation constant.
package approx_mul_pkg;

    localparam int WIDTH_MIN  = 4;
    localparam int WIDTH_MAX  = 16;
    localparam int TRUNC_MIN  = 0;
    localparam int STAGES_MIN = 1;
    localparam int STAGES_MAX = 4;

    // Half the weight of the lowest kept column. This recentres the error
    // introduced by dropping the low columns.
    function automatic logic [31:0] comp_const(input int trunc_cols);
        return (trunc_cols > 0) ? (32'd1 << (trunc_cols - 1)) : 32'd0;
    endfunction

endpackage

// File: rtl/approx_pp_compress.sv
// Partial-product generator with optional low-column truncation, reduced to a
// redundant sum/carry pair by a chain of 3:2 carry-save adders.
module approx_pp_compress
    import approx_mul_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int TRUNC_COLS = 4
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               approx,
    output logic [2*WIDTH-1:0] sum_row,
    output logic [2*WIDTH-1:0] carry_row
);

    localparam int PW = 2 * WIDTH;
    localparam logic [PW-1:0] KEEP_MASK = ~((PW'(1) << TRUNC_COLS) - PW'(1));
    localparam logic [PW-1:0] COMP      = PW'(comp_const(TRUNC_COLS));

    logic [PW-1:0] mask;
    logic [PW-1:0] row;
    logic [PW-1:0] s;
    logic [PW-1:0] c;
    logic [PW-1:0] maj;

    // The compensation constant seeds the sum row, so it costs no extra adder.
    // Carries leaving the top bit are dropped: the true total fits in PW bits.
    always_comb begin
        mask = approx ? KEEP_MASK : '1;
        s    = approx ? COMP : '0;
        c    = '0;
        row  = '0;
        maj  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            row = a[i] ? ((PW'(b) << i) & mask) : '0;
            maj = (s & c) | (s & row) | (c & row);
            s   = s ^ c ^ row;
            c   = maj << 1;
        end
    end

    assign sum_row   = s;
    assign carry_row = c;

endmodule

// File: rtl/approx_mul_pipe.sv
// Pipelined unsigned multiplier with a per-beat exact/approximate mode and a
// valid/ready handshake. Stage 1 compresses, the last stage does the final add.
module approx_mul_pipe
    import approx_mul_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int TRUNC_COLS = 4,
    parameter int STAGES     = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic               in_approx,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_p,
    output logic               out_approx,
    output logic [31:0]        approx_cnt
);

    localparam int PW = 2 * WIDTH;

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
        $error("approx_mul_pipe: WIDTH out of range");
    end
    if (TRUNC_COLS < TRUNC_MIN || TRUNC_COLS > WIDTH) begin : g_bad_trunc
        $error("approx_mul_pipe: TRUNC_COLS out of range");
    end
    if (STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_bad_stages
        $error("approx_mul_pipe: STAGES out of range");
    end

    typedef struct packed {
        logic [PW-1:0] s;
        logic [PW-1:0] c;
        logic          m;
    } rows_t;

    logic              adv;
    logic              accept;
    logic [STAGES:0]   vld_pipe;
    logic [STAGES:1]   vld_q;
    logic [PW-1:0]     cs_s;
    logic [PW-1:0]     cs_c;
    rows_t             rows_in;
    rows_t             rows_fin;
    logic [PW-1:0]     p_q;
    logic              m_q;
    logic [31:0]       cnt_q;

    // The whole pipeline moves as one; it only stalls on a blocked output.
    assign adv      = !vld_pipe[STAGES] || out_ready;
    assign in_ready = adv;
    assign accept   = in_valid && adv;
    assign vld_pipe = {vld_q, accept};

    approx_pp_compress #(
        .WIDTH      (WIDTH),
        .TRUNC_COLS (TRUNC_COLS)
    ) u_compress (
        .a         (in_a),
        .b         (in_b),
        .approx    (in_approx),
        .sum_row   (cs_s),
        .carry_row (cs_c)
    );

    assign rows_in = {cs_s, cs_c, in_approx};

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
        end else if (adv) begin
            vld_q <= vld_pipe[STAGES-1:0];
        end
    end

    if (STAGES == 1) begin : g_direct
        assign rows_fin = rows_in;
    end else begin : g_rows
        rows_t [STAGES-2:0] rows_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                rows_q <= '0;
            end else if (adv) begin
                rows_q[0] <= rows_in;
                for (int k = 1; k < STAGES - 1; k++) begin
                    rows_q[k] <= rows_q[k-1];
                end
            end
        end

        assign rows_fin = rows_q[STAGES-2];
    end

    // Final carry-propagate add into the output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            p_q <= '0;
            m_q <= 1'b0;
        end else if (adv) begin
            p_q <= rows_fin.s + rows_fin.c;
            m_q <= rows_fin.m;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (accept && in_approx) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    assign out_valid  = vld_pipe[STAGES];
    assign out_p      = p_q;
    assign out_approx = m_q;
    assign approx_cnt = cnt_q;

endmodule

// File: tb/tb_approx_mul_pipe.sv
// Self-checking bench for approx_mul_pipe (WIDTH=8, TRUNC_COLS=4, STAGES=2):
// vector table, hand sequences for stall/reset/wrap, and a scoreboard queue.
module tb_approx_mul_pipe;

    localparam int W = 8;
    localparam int T = 4;
    localparam int S = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   in_a = '0;
    logic [W-1:0]   in_b = '0;
    logic           in_approx = 1'b0;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [2*W-1:0] out_p;
    logic           out_approx;
    logic [31:0]    approx_cnt;

    approx_mul_pipe #(.WIDTH(W), .TRUNC_COLS(T), .STAGES(S)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_approx  (in_approx),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_p      (out_p),
        .out_approx (out_approx),
        .approx_cnt (approx_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic           m;
        logic [2*W-1:0] p;
    } vec_t;

    typedef struct {
        logic [2*W-1:0] p;
        logic           m;
    } exp_t;

    int          checks = 0;
    int          failures = 0;
    exp_t        exp_q[$];
    int unsigned cnt_model = 0;
    logic        held_vld = 1'b0;
    logic [2*W-1:0] held_p = '0;
    logic        held_m = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", name, act, want);
        end
    endtask

    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic m);
        int unsigned acc;
        acc = 0;
        for (int i = 0; i < W; i++)
            for (int j = 0; j < W; j++)
                if (a[i] && b[j] && (!m || (i + j) >= T)) acc += (32'd1 << (i + j));
        if (m && T > 0) acc += (32'd1 << (T - 1));
        return acc[2*W-1:0];
    endfunction

    // One clock cycle: drive inputs after the falling edge, settle, score the
    // handshakes that the next rising edge will complete, then wait.
    task automatic tick(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic m, input logic ordy, input logic r,
                        input logic [2*W-1:0] exp_p, output logic acc);
        exp_t e;
        in_valid = v; in_a = a; in_b = b; in_approx = m; out_ready = ordy; rst = r;
        #1;
        acc = !r && in_valid && in_ready;
        if (held_vld) begin
            chk("hold_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_p", {16'd0, out_p}, {16'd0, held_p});
            chk("hold_mode", {31'd0, out_approx}, {31'd0, held_m});
        end
        held_vld = !r && out_valid && !out_ready;
        held_p   = out_p;
        held_m   = out_approx;
        if (!r && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL spurious_out got=%0d want=none", out_p);
            end else begin
                e = exp_q.pop_front();
                chk("out_p", {16'd0, out_p}, {16'd0, e.p});
                chk("out_mode", {31'd0, out_approx}, {31'd0, e.m});
            end
        end
        if (acc) begin
            e.p = exp_p; e.m = m;
            exp_q.push_back(e);
            if (m) cnt_model++;
        end
        if (r) begin
            exp_q.delete();
            cnt_model = 0;
            held_vld = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) tick(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, '0, acc);
    endtask

    task automatic do_reset();
        logic acc;
        tick(1'b0, '0, '0, 1'b0, 1'b1, 1'b1, '0, acc);
        tick(1'b0, '0, '0, 1'b0, 1'b1, 1'b1, '0, acc);
    endtask

    task automatic drain(input string name);
        logic acc;
        for (int i = 0; i < 20 && exp_q.size() > 0; i++)
            tick(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, '0, acc);
        chk(name, exp_q.size(), 32'd0);
        idle(3);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t tbl[12];
        logic acc;
        logic [W-1:0] ra, rb;
        logic rm, rv;
        int k, c, guard;
        vec_t bt[4];

        tbl[0]  = '{8'd255, 8'd255, 1'b0, 16'd65025};
        tbl[1]  = '{8'd255, 8'd255, 1'b1, 16'd64984};
        tbl[2]  = '{8'd15,  8'd15,  1'b1, 16'd184};
        tbl[3]  = '{8'd16,  8'd16,  1'b1, 16'd264};
        tbl[4]  = '{8'd0,   8'd0,   1'b1, 16'd8};
        tbl[5]  = '{8'd0,   8'd0,   1'b0, 16'd0};
        tbl[6]  = '{8'd1,   8'd1,   1'b0, 16'd1};
        tbl[7]  = '{8'd1,   8'd1,   1'b1, 16'd8};
        tbl[8]  = '{8'd3,   8'd3,   1'b1, 16'd8};
        tbl[9]  = '{8'd200, 8'd3,   1'b0, 16'd600};
        tbl[10] = '{8'd15,  8'd15,  1'b0, 16'd225};
        tbl[11] = '{8'd128, 8'd255, 1'b1, 16'd32648};

        bt[0] = '{8'd255, 8'd255, 1'b0, 16'd65025};
        bt[1] = '{8'd15,  8'd15,  1'b1, 16'd184};
        bt[2] = '{8'd16,  8'd16,  1'b1, 16'd264};
        bt[3] = '{8'd12,  8'd10,  1'b0, 16'd120};

        @(negedge clk);
        do_reset();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_p", {16'd0, out_p}, 32'd0);
        chk("rst_out_approx", {31'd0, out_approx}, 32'd0);
        chk("rst_cnt", approx_cnt, 32'd0);
        rst = 1'b0; #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);

        // Latency: exact beat appears exactly two edges after acceptance.
        tick(1'b1, 8'd255, 8'd255, 1'b0, 1'b1, 1'b0, 16'd65025, acc);
        chk("lat_accept", {31'd0, acc}, 32'd1);
        chk("lat1_valid", {31'd0, out_valid}, 32'd0);
        idle(1);
        chk("lat2_valid", {31'd0, out_valid}, 32'd1);
        chk("lat2_p", {16'd0, out_p}, 32'd65025);
        chk("lat2_mode", {31'd0, out_approx}, 32'd0);
        drain("lat_drain");

        for (int i = 0; i < 12; i++) begin
            tick(1'b1, tbl[i].a, tbl[i].b, tbl[i].m, 1'b1, 1'b0, tbl[i].p, acc);
            chk("tbl_accept", {31'd0, acc}, 32'd1);
        end
        drain("tbl_drain");

        // Back-to-back beats with the sink stalled for cycles 2..4.
        k = 0; c = 0;
        while (k < 4 && c < 40) begin
            tick(1'b1, bt[k].a, bt[k].b, bt[k].m, !(c >= 2 && c <= 4), 1'b0, bt[k].p, acc);
            if (c >= 2 && c <= 4) chk("stall_in_ready", {31'd0, acc}, 32'd0);
            if (acc) k++;
            c++;
        end
        chk("stall_all_sent", k, 32'd4);
        drain("stall_drain");

        // Reset with beats in flight, plus a beat offered during reset.
        tick(1'b1, 8'd15, 8'd15, 1'b1, 1'b1, 1'b0, 16'd184, acc);
        tick(1'b1, 8'd0, 8'd0, 1'b1, 1'b1, 1'b0, 16'd8, acc);
        tick(1'b1, 8'd1, 8'd1, 1'b1, 1'b1, 1'b1, 16'd8, acc);
        chk("midrst_accept", {31'd0, acc}, 32'd0);
        chk("midrst_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_cnt", approx_cnt, 32'd0);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        idle(6);
        chk("midrst_cnt_after", approx_cnt, 32'd0);

        // Approximate sweep, then exact sweep, each over a 64x64 operand block.
        do_reset();
        for (int a = 0; a < 64; a++)
            for (int b = 0; b < 64; b++)
                tick(1'b1, W'(a), W'(b), 1'b1, 1'b1, 1'b0, ref_mul(W'(a), W'(b), 1'b1), acc);
        drain("sweep_a_drain");
        chk("sweep_a_cnt", approx_cnt, 32'd4096);
        for (int a = 192; a < 256; a++)
            for (int b = 192; b < 256; b++)
                tick(1'b1, W'(a), W'(b), 1'b0, 1'b1, 1'b0, ref_mul(W'(a), W'(b), 1'b0), acc);
        drain("sweep_e_drain");
        chk("sweep_e_cnt", approx_cnt, 32'd4096);

        // Random operands, modes, bubbles and back-pressure.
        do_reset();
        ra = W'($urandom); rb = W'($urandom); rm = 1'($urandom);
        k = 0; guard = 0;
        while (k < 3000 && guard < 30000) begin
            rv = ($urandom_range(0, 3) != 0);
            tick(rv, ra, rb, rm, ($urandom_range(0, 3) != 0), 1'b0, ref_mul(ra, rb, rm), acc);
            if (acc) begin
                k++;
                ra = W'($urandom); rb = W'($urandom); rm = 1'($urandom);
            end
            guard++;
        end
        chk("rand_sent", k, 32'd3000);
        drain("rand_drain");
        chk("rand_cnt", approx_cnt, cnt_model);

        // Counter wrap from all-ones.
        force dut.cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.cnt_q;
        chk("wrap_preload", approx_cnt, 32'hFFFF_FFFF);
        @(negedge clk);
        tick(1'b1, 8'd3, 8'd5, 1'b1, 1'b1, 1'b0, ref_mul(8'd3, 8'd5, 1'b1), acc);
        chk("wrap_cnt", approx_cnt, 32'd0);
        drain("wrap_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
